pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_lock_sequencer.sv | 176 +++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: resets the PLL, waits for lock, debounces it, then releases sys_rst_n; bounded retries, then FAIL.
// Outputs registered from next state (no backpressure); define PLL_LOCK_SEQ_STATS_EN to build the lock-loss counter.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_stdy_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic        sync1_q, sync2_q;
  logic        locked_s;
  logic        stdy_rst_q, stdy_rst_d;
  logic        sys_rst_n_q, sys_rst_n_d;
  logic        ready_q, ready_d;
  logic        fail_q, fail_d;

  // pll_locked is asynchronous; only the second flop is ever looked at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  assign locked_s = sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST_PLL;
      cnt_q   <= 16'd0;
      retry_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (restart) begin
      state_d = ST_RST_PLL;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        ST_RST_PLL: begin
          if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_SETTLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q < RETRY_MAX) begin
              state_d = ST_RST_PLL;
              retry_d = retry_q + 4'd1;
            end else begin
              state_d = ST_FAIL;
            end
          end
        end
        ST_SETTLE: begin
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == SETTLE_LAST) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d = ST_RST_PLL;
            retry_d = 4'd0;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_RST_PLL;
          retry_d = 4'd0;
        end
      endcase
    end
  end

  // A restart while already in RST_PLL must still give a full reset pulse.
  always_comb begin
    if (restart || (state_d != state_q)) begin
      cnt_d = 16'd0;
    end else if (cnt_q == 16'hFFFF) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    stdy_rst_d  = (state_d == ST_RST_PLL);
    sys_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stdy_rst_q  <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      stdy_rst_q  <= stdy_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_stdy_rst = stdy_rst_q;
  assign sys_rst_n    = sys_rst_n_q;
  assign ready        = ready_q;
  assign fail         = fail_q;
  assign retry_cnt    = retry_q;

`ifdef PLL_LOCK_SEQ_STATS_EN
  logic [7:0] lock_loss_q, lock_loss_d;
  logic       lock_loss_evt;

  // Leaving RUN for RST_PLL without a restart can only mean lock loss.
  assign lock_loss_evt = (state_q == ST_RUN) && (state_d == ST_RST_PLL) && !restart;

  always_comb begin
    lock_loss_d = lock_loss_q;
    if (lock_loss_evt && (lock_loss_q != 8'hFF)) lock_loss_d = lock_loss_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_loss_q <= 8'd0;
    else        lock_loss_q <= lock_loss_d;
  end

  assign lock_loss_cnt = lock_loss_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: expected output changes are queued with their cycle; a monitor matches them.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

  localparam int RC = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int MR = 2;
`ifdef PLL_LOCK_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [15:0] RESET_VEC = 16'h8000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_stdy_rst, sys_rst_n, ready, fail;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [15:0] out_vec;

  pll_lock_sequencer #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .SETTLE_CYCLES(SC), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .restart(restart),
    .pll_stdy_rst(pll_stdy_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  assign out_vec = {pll_stdy_rst, sys_rst_n, ready, fail, retry_cnt, lock_loss_cnt};

  // cycle n = the period after the n-th rising edge since reset release
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int          cyc;
    logic [15:0] vec;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cmd = 0;
  logic [15:0] async_exp = 16'h0;
  event        async_ev;

  function automatic logic [15:0] mk(input logic stdy, input logic sysn, input logic rdy,
                                     input logic fl, input logic [3:0] rc, input logic [7:0] ll);
    return {stdy, sysn, rdy, fl, rc, ll};
  endfunction

  function automatic logic [7:0] ll_exp(input int k);
    if (!STATS) return 8'd0;
    return (k > 255) ? 8'd255 : 8'(k);
  endfunction

  task automatic push(input int c, input logic [15:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    q.push_back(e);
  endtask

  initial begin : monitor
    logic [15:0] prev;
    exp_t        e;
    prev = RESET_VEC;
    forever begin
      @(negedge clk or async_ev);
      if (clk === 1'b1) begin
        if (cmd == 1) begin
          n_cmp++;
          if (out_vec !== async_exp) begin
            n_bad++;
            $display("FAIL async_reset_outputs: got %h, want %h", out_vec, async_exp);
          end
        end else begin
          while (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_event: never saw %h at cycle %0d (now cycle %0d)", e.vec, e.cyc, cyc);
          end
        end
        prev = out_vec;
      end else begin
        if (rst_n && (out_vec !== prev)) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_change: got %h at cycle %0d, want no change from %h", out_vec, cyc, prev);
          end else begin
            e = q.pop_front();
            if ((e.cyc != cyc) || (e.vec !== out_vec)) begin
              n_bad++;
              $display("FAIL output_event: got %h at cycle %0d, want %h at cycle %0d", out_vec, cyc, e.vec, e.cyc);
            end
          end
        end
        prev = out_vec;
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Caller guarantees clk is high here, which is how the monitor tells this apart from a negedge.
  task automatic async_check();
    async_exp = RESET_VEC;
    cmd = 1;
    -> async_ev;
    #1;
  endtask

  task automatic flush();
    @(posedge clk);
    #2;
    cmd = 2;
    -> async_ev;
    #1;
  endtask

  task automatic do_reset(input logic lk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    restart = 1'b0;
    pll_locked = lk;
    #1;
    async_check();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int r;

    // Nominal lock, release, then a lock loss in RUN
    do_reset(1'b0);
    push(4,  mk(0, 0, 0, 0, 4'd0, 8'd0));
    push(21, mk(0, 1, 1, 0, 4'd0, 8'd0));
    push(33, mk(1, 0, 0, 0, 4'd0, ll_exp(1)));
    push(37, mk(0, 0, 0, 0, 4'd0, ll_exp(1)));
    wait_cyc(10); pll_locked = 1'b1;
    wait_cyc(30); pll_locked = 1'b0;
    wait_cyc(45);
    flush();

    // No lock: retries exhaust into FAIL, restart from FAIL, restart coincident with timeout
    do_reset(1'b0);
    push(4,   mk(0, 0, 0, 0, 4'd0, 8'd0));
    push(24,  mk(1, 0, 0, 0, 4'd1, 8'd0));
    push(28,  mk(0, 0, 0, 0, 4'd1, 8'd0));
    push(48,  mk(1, 0, 0, 0, 4'd2, 8'd0));
    push(52,  mk(0, 0, 0, 0, 4'd2, 8'd0));
    push(72,  mk(0, 0, 0, 1, 4'd2, 8'd0));
    push(81,  mk(1, 0, 0, 0, 4'd0, 8'd0));
    push(85,  mk(0, 0, 0, 0, 4'd0, 8'd0));
    push(105, mk(1, 0, 0, 0, 4'd0, 8'd0));
    push(109, mk(0, 0, 0, 0, 4'd0, 8'd0));
    wait_cyc(80);  restart = 1'b1;
    wait_cyc(81);  restart = 1'b0;
    wait_cyc(104); restart = 1'b1;
    wait_cyc(105); restart = 1'b0;
    wait_cyc(115);
    flush();

    // One-cycle glitch in SETTLE restarts the settle count
    do_reset(1'b0);
    push(4,  mk(0, 0, 0, 0, 4'd0, 8'd0));
    push(28, mk(0, 1, 1, 0, 4'd0, 8'd0));
    wait_cyc(10); pll_locked = 1'b1;
    wait_cyc(16); pll_locked = 1'b0;
    wait_cyc(17); pll_locked = 1'b1;
    wait_cyc(35);
    flush();

    // Asynchronous reset in the middle of SETTLE
    do_reset(1'b0);
    push(4, mk(0, 0, 0, 0, 4'd0, 8'd0));
    wait_cyc(10); pll_locked = 1'b1;
    wait_cyc(16);
    #1;
    rst_n = 1'b0;
    #1;
    async_check();
    flush();

    // 300 lock losses from RUN: counter saturates at 255
    do_reset(1'b1);
    push(4,  mk(0, 0, 0, 0, 4'd0, 8'd0));
    push(13, mk(0, 1, 1, 0, 4'd0, 8'd0));
    r = 13;
    for (int k = 1; k <= 300; k++) begin
      push(r + 5,  mk(1, 0, 0, 0, 4'd0, ll_exp(k)));
      push(r + 9,  mk(0, 0, 0, 0, 4'd0, ll_exp(k)));
      push(r + 18, mk(0, 1, 1, 0, 4'd0, ll_exp(k)));
      r += 18;
    end
    r = 13;
    for (int k = 1; k <= 300; k++) begin
      wait_cyc(r + 2); pll_locked = 1'b0;
      wait_cyc(r + 3); pll_locked = 1'b1;
      r += 18;
    end
    wait_cyc(r + 5);
    flush();

    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
